// File: rtl/reg_file_stream_reader.sv
// reg_file_stream_reader: streams a register-file address window on valid/ready; `RF_STREAM_LAST_EN adds data_last_o
module reg_file_stream_reader #(
  parameter int DataWidth    = 32,
  parameter int NumRegs      = 32,
  parameter int NumRegsWidth = $clog2(NumRegs)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [NumRegsWidth-1:0] base_addr_i,
  input  logic [NumRegsWidth:0]   num_words_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [NumRegsWidth-1:0] rf_rd_addr_o,
  input  logic [DataWidth-1:0]    rf_rd_data_i,
  output logic [DataWidth-1:0]    data_o,
  output logic                    data_valid_o,
  input  logic                    data_ready_i
`ifdef RF_STREAM_LAST_EN
  ,
  output logic                    data_last_o
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e                  state_q, state_d;
  logic [NumRegsWidth-1:0] addr_q, addr_d;
  logic [NumRegsWidth:0]   rem_q, rem_d;
  logic [DataWidth-1:0]    data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    load;
`ifdef RF_STREAM_LAST_EN
  logic                    last_q, last_d;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef RF_STREAM_LAST_EN
    last_d  = last_q;
`endif
    load = (state_q == RUN) && (!valid_q || data_ready_i);
    if (state_q == IDLE && start_i) begin
      if (num_words_i == '0) begin
        done_d = 1'b1;
      end else begin
        addr_d  = base_addr_i;
        rem_d   = num_words_i > (NumRegsWidth+1)'(NumRegs) ? (NumRegsWidth+1)'(NumRegs) : num_words_i;
        state_d = RUN;
      end
    end
    if (load) begin
      data_d  = rf_rd_data_i;
      valid_d = 1'b1;
      rem_d   = rem_q - (NumRegsWidth+1)'(1);
      addr_d  = addr_q == NumRegsWidth'(NumRegs - 1) ? '0 : addr_q + 1'b1;
      state_d = rem_q == (NumRegsWidth+1)'(1) ? DRAIN : RUN;
`ifdef RF_STREAM_LAST_EN
      last_d  = rem_q == (NumRegsWidth+1)'(1);
`endif
    end
    if (state_q == DRAIN && valid_q && data_ready_i) begin
      valid_d = 1'b0;
      done_d  = 1'b1;
      state_d = IDLE;
`ifdef RF_STREAM_LAST_EN
      last_d  = 1'b0;
`endif
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef RF_STREAM_LAST_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef RF_STREAM_LAST_EN
      last_q  <= last_d;
`endif
    end
  end
  assign busy_o       = state_q != IDLE;
  assign done_o       = done_q;
  assign rf_rd_addr_o = addr_q;
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
`ifdef RF_STREAM_LAST_EN
  assign data_last_o  = last_q;
`endif
endmodule

// File: tb/tb_reg_file_stream_reader.sv
// tb_reg_file_stream_reader: directed self-checking bench for reg_file_stream_reader
module tb_reg_file_stream_reader;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [4:0]  base_addr_i = '0;
  logic [5:0]  num_words_i = '0;
  logic        busy_o, done_o, data_valid_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_rd_data_i, data_o;
  logic        data_ready_i = 1'b0;
`ifdef RF_STREAM_LAST_EN
  logic        data_last_o;
`endif
  logic [31:0] rf [32];
  int compared = 0;
  int mismatched = 0;
  always #5 clk_i = ~clk_i;
  assign rf_rd_data_i = rf[rf_rd_addr_o];
  reg_file_stream_reader dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .busy_o(busy_o), .done_o(done_o),
    .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_i(rf_rd_data_i), .data_o(data_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i)
`ifdef RF_STREAM_LAST_EN
    , .data_last_o(data_last_o)
`endif
  );
  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if ({busy_o, done_o, data_valid_o} !== 3'b000 || rf_rd_addr_o !== 5'd0 || data_o !== 32'd0) begin
        mismatched++;
        $display("FAIL reset_outputs step=%0d got busy=%b done=%b valid=%b addr=%0d data=%0d want all 0", i, busy_o, done_o, data_valid_o, rf_rd_addr_o, data_o);
      end
`ifdef RF_STREAM_LAST_EN
      compared++;
      if (data_last_o !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_last got %b want 0", data_last_o);
      end
`endif
      rst_i = 1'b0;
      @(negedge clk_i);
    end
  endtask
  task automatic test_stream(input string name, input int base, input int num, input int exp_words);
    int k, dones, first, done_cyc;
    start_i = 1'b1; base_addr_i = 5'(base); num_words_i = 6'(num); data_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    k = 0; dones = 0; first = -1; done_cyc = -1;
    for (int c = 1; c <= exp_words + 8; c++) begin
      if (data_valid_o && first < 0) first = c;
      if (data_valid_o && data_ready_i) begin
        compared++;
        if (data_o !== 32'(((base + k) % 32) + 100)) begin
          mismatched++;
          $display("FAIL %s_data word=%0d got %0d want %0d", name, k, data_o, ((base + k) % 32) + 100);
        end
`ifdef RF_STREAM_LAST_EN
        compared++;
        if (data_last_o !== (k == exp_words - 1)) begin
          mismatched++;
          $display("FAIL %s_last word=%0d got %b want %b", name, k, data_last_o, k == exp_words - 1);
        end
`endif
        k++;
      end
      if (done_o) begin
        dones++;
        done_cyc = c;
      end
      @(negedge clk_i);
    end
    compared++;
    if (k !== exp_words || dones !== 1) begin
      mismatched++;
      $display("FAIL %s_count got words=%0d dones=%0d want words=%0d dones=1", name, k, dones, exp_words);
    end
    compared++;
    if (first !== 2 || done_cyc !== exp_words + 2) begin
      mismatched++;
      $display("FAIL %s_timing got first=%0d done=%0d want first=2 done=%0d", name, first, done_cyc, exp_words + 2);
    end
  endtask
  task automatic test_backpressure();
    logic [5:0]  pat;
    logic [31:0] held_data;
    logic        held;
    int k, dones;
    pat = 6'b100100;
    start_i = 1'b1; base_addr_i = 5'd5; num_words_i = 6'd3; data_ready_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    k = 0; dones = 0; held = 1'b0; held_data = '0;
    for (int c = 1; c <= 14; c++) begin
      data_ready_i = c > 5 ? 1'b1 : pat[c];
      if (held && data_valid_o) begin
        compared++;
        if (data_o !== held_data) begin
          mismatched++;
          $display("FAIL bp_stable cycle=%0d got %0d want %0d", c, data_o, held_data);
        end
      end
      held = data_valid_o && !data_ready_i;
      held_data = data_o;
      if (data_valid_o && data_ready_i) begin
        compared++;
        if (data_o !== 32'(105 + k)) begin
          mismatched++;
          $display("FAIL bp_data word=%0d got %0d want %0d", k, data_o, 105 + k);
        end
        k++;
      end
      if (done_o) dones++;
      @(negedge clk_i);
    end
    compared++;
    if (k !== 3 || dones !== 1) begin
      mismatched++;
      $display("FAIL bp_count got words=%0d dones=%0d want words=3 dones=1", k, dones);
    end
  endtask
  task automatic test_zero();
    start_i = 1'b1; base_addr_i = 5'd7; num_words_i = 6'd0; data_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    compared++;
    if (done_o !== 1'b1 || data_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_done got done=%b valid=%b busy=%b want 1 0 0", done_o, data_valid_o, busy_o);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      compared++;
      if (done_o !== 1'b0 || data_valid_o !== 1'b0) begin
        mismatched++;
        $display("FAIL zero_after cycle=%0d got done=%b valid=%b want 0 0", c, done_o, data_valid_o);
      end
    end
  endtask
  task automatic test_abort();
    int k, dones;
    start_i = 1'b1; base_addr_i = 5'd0; num_words_i = 6'd8; data_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    k = 0;
    for (int c = 0; c < 10 && k < 2; c++) begin
      if (data_valid_o && data_ready_i) k++;
      if (k < 2) @(negedge clk_i);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    compared++;
    if (k !== 2 || busy_o !== 1'b0 || data_valid_o !== 1'b0 || done_o !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_state got words=%0d busy=%b valid=%b done=%b want 2 0 0 0", k, busy_o, data_valid_o, done_o);
    end
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      if (done_o || data_valid_o) dones++;
      @(negedge clk_i);
    end
    compared++;
    if (dones !== 0) begin
      mismatched++;
      $display("FAIL abort_quiet got %0d active cycles want 0", dones);
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(i + 100);
    test_reset();
    test_stream("basic", 2, 4, 4);
    test_stream("wrap", 30, 4, 4);
    test_backpressure();
    test_zero();
    test_stream("clamp", 0, 40, 32);
    test_abort();
    test_stream("restart", 10, 2, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
